mem_bus_arbiter: RTL and testbench

- Shares the system memory map between the CPU instruction-fetch port and the load/store port.
- Arbitrates between the two master requests round-robin.
- Decodes each address into the BRAM or UART region and sequences one single-outstanding transaction to the selected slave.
- Returns read data, completion and error (unmapped address or slave timeout) to the requester.
- Sits between the CPU core and the BRAM/UART slaves.

---
 rtl/mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin IM/DM master arbiter with BRAM/UART
// address decode and one single-outstanding slave transaction.
// Ports:
//   clk, reset_n       - clock, async active-low reset
//   im_*               - fetch master (addr/valid in, rdata/ready/err out)
//   dm_*               - load/store master (addr/wdata/wmask/we/valid in,
//                        rdata/ready/err out)
//   s_addr/wdata/wmask/we - shared slave payload (region-relative addr)
//   bram_valid/rdata/ready, uart_valid/rdata/ready - per-slave handshake
module mem_bus_arbiter #(
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] BRAM_LEN  = 32'h0001_0000,
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter logic [31:0] UART_LEN  = 32'h0000_0028,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] im_addr,
  input  logic        im_valid,
  output logic [31:0] im_rdata,
  output logic        im_ready,
  output logic        im_err,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wmask,
  input  logic        dm_we,
  input  logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_we,
  output logic        bram_valid,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,
  output logic        uart_valid,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] im_rdata_q, im_rdata_d;
  logic        im_ready_q, im_ready_d;
  logic        im_err_q, im_err_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        dm_ready_q, dm_ready_d;
  logic        dm_err_q, dm_err_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wmask_q, s_wmask_d;
  logic        s_we_q, s_we_d;
  logic        bram_valid_q, bram_valid_d;
  logic        uart_valid_q, uart_valid_d;

  // last_q/gnt_q: 1 = DM. last_q only moves on contention.
  logic        pick_dm;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_we;

  always_comb begin
    pick_dm = dm_valid & (~im_valid | ~last_q);
    r_addr  = pick_dm ? dm_addr : im_addr;
    r_wdata = pick_dm ? dm_wdata : 32'h0;
    r_wmask = pick_dm ? dm_wmask : 4'hf;
    r_we    = pick_dm & dm_we;
  end

  // 33-bit difference: bit 32 is the borrow, set when addr < base.
  logic [32:0] b_diff;
  logic [32:0] u_diff;
  logic        b_hit;
  logic        u_hit;

  assign b_diff = {1'b0, r_addr} - {1'b0, BRAM_BASE};
  assign u_diff = {1'b0, r_addr} - {1'b0, UART_BASE};
  assign b_hit  = ~b_diff[32] & (b_diff[31:0] < BRAM_LEN);
  assign u_hit  = ~u_diff[32] & (u_diff[31:0] < UART_LEN);

  logic        fin;
  logic        fin_err;
  logic [31:0] fin_data;
  logic        slv_rdy;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    im_rdata_d   = im_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    im_ready_d   = 1'b0;
    im_err_d     = 1'b0;
    dm_ready_d   = 1'b0;
    dm_err_d     = 1'b0;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wmask_d    = s_wmask_q;
    s_we_d       = s_we_q;
    bram_valid_d = bram_valid_q;
    uart_valid_d = uart_valid_q;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_data     = 32'h0;
    slv_rdy      = sel_q ? uart_ready : bram_ready;

    unique case (state_q)
      IDLE: begin
        if (im_valid || dm_valid) begin
          gnt_d     = pick_dm;
          if (im_valid && dm_valid) last_d = pick_dm;
          s_wdata_d = r_wdata;
          s_wmask_d = r_wmask;
          s_we_d    = r_we;
          cnt_d     = 8'h0;
          if (b_hit) begin
            s_addr_d     = b_diff[31:0];
            sel_d        = 1'b0;
            bram_valid_d = 1'b1;
            state_d      = BUSY;
          end else if (u_hit) begin
            s_addr_d     = u_diff[31:0];
            sel_d        = 1'b1;
            uart_valid_d = 1'b1;
            state_d      = BUSY;
          end else begin
            s_addr_d = r_addr;
            fin      = 1'b1;
            fin_err  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (slv_rdy) begin
          fin      = 1'b1;
          fin_data = sel_q ? uart_rdata : bram_rdata;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
        if (fin) begin
          bram_valid_d = 1'b0;
          uart_valid_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'h0;
      end
      default: state_d = IDLE;
    endcase

    // Completion is registered so the pulse lands in the DONE cycle.
    if (fin) begin
      if (gnt_d) begin
        dm_ready_d = 1'b1;
        dm_err_d   = fin_err;
        dm_rdata_d = fin_data;
      end else begin
        im_ready_d = 1'b1;
        im_err_d   = fin_err;
        im_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      gnt_q        <= 1'b0;
      sel_q        <= 1'b0;
      cnt_q        <= 8'h0;
      im_rdata_q   <= 32'h0;
      im_ready_q   <= 1'b0;
      im_err_q     <= 1'b0;
      dm_rdata_q   <= 32'h0;
      dm_ready_q   <= 1'b0;
      dm_err_q     <= 1'b0;
      s_addr_q     <= 32'h0;
      s_wdata_q    <= 32'h0;
      s_wmask_q    <= 4'h0;
      s_we_q       <= 1'b0;
      bram_valid_q <= 1'b0;
      uart_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      im_rdata_q   <= im_rdata_d;
      im_ready_q   <= im_ready_d;
      im_err_q     <= im_err_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_ready_q   <= dm_ready_d;
      dm_err_q     <= dm_err_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wmask_q    <= s_wmask_d;
      s_we_q       <= s_we_d;
      bram_valid_q <= bram_valid_d;
      uart_valid_q <= uart_valid_d;
    end
  end

  assign im_rdata   = im_rdata_q;
  assign im_ready   = im_ready_q;
  assign im_err     = im_err_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_ready   = dm_ready_q;
  assign dm_err     = dm_err_q;
  assign s_addr     = s_addr_q;
  assign s_wdata    = s_wdata_q;
  assign s_wmask    = s_wmask_q;
  assign s_we       = s_we_q;
  assign bram_valid = bram_valid_q;
  assign uart_valid = uart_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter.
// Memory-map reference model, slave responders and a decoupled monitor.
module tb_mem_bus_arbiter;

  localparam int TO = 16;

  logic        clk;
  logic        reset_n;
  logic [31:0] im_addr;
  logic        im_valid;
  logic [31:0] im_rdata;
  logic        im_ready;
  logic        im_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;
  logic        dm_we;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_err;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_we;
  logic        bram_valid;
  logic [31:0] bram_rdata;
  logic        bram_ready;
  logic        uart_valid;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .im_addr(im_addr), .im_valid(im_valid),
    .im_rdata(im_rdata), .im_ready(im_ready), .im_err(im_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_we(dm_we), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_we(s_we),
    .bram_valid(bram_valid), .bram_rdata(bram_rdata),
    .bram_ready(bram_ready),
    .uart_valid(uart_valid), .uart_rdata(uart_rdata),
    .uart_ready(uart_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave behaviour: slat = cycles of valid before ready, 0 = never.
  int          slat = 2;
  bit          spur = 1'b0;
  logic [31:0] bram_data = 32'h0;
  logic [31:0] uart_data = 32'h0;
  bit          ref_last = 1'b0;

  typedef struct {
    bit          dm;
    int          region;
    logic [31:0] off;
    bit          we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          busy;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t predict(bit dm, logic [31:0] addr, bit we,
                                   logic [31:0] wd, logic [3:0] m);
    exp_t e;
    longint unsigned a;
    a       = 64'(addr);
    e.dm    = dm;
    e.we    = dm & we;
    e.mask  = dm ? m : 4'hf;
    e.wdata = dm ? wd : 32'h0;
    if (a < 64'h1_0000) begin
      e.region = 0;
      e.off    = addr;
    end else if (a >= 64'h1000_0000 && a < 64'h1000_0028) begin
      e.region = 1;
      e.off    = addr - 32'h1000_0000;
    end else begin
      e.region = 2;
      e.off    = 32'h0;
    end
    e.busy  = (slat == 0) ? TO : slat;
    e.err   = (e.region == 2) || (slat == 0);
    e.rdata = e.err ? 32'h0 : (e.region == 0 ? bram_data : uart_data);
    return e;
  endfunction

  function automatic int own(exp_t e);
    return (e.region == 2) ? 1 : e.busy + 1;
  endfunction

  // Slave responders.
  initial begin
    int bc;
    int uc;
    bc = 0;
    uc = 0;
    bram_ready = 1'b0;
    uart_ready = 1'b0;
    bram_rdata = 32'h0;
    uart_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bram_rdata = bram_data;
      uart_rdata = uart_data;
      if (bram_valid) begin
        bc++;
        bram_ready = (slat != 0) && (bc == slat);
      end else begin
        bc = 0;
        bram_ready = spur && ($urandom_range(0, 3) == 0);
      end
      if (uart_valid) begin
        uc++;
        uart_ready = (slat != 0) && (uc == slat);
      end else begin
        uc = 0;
        uart_ready = spur && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: slave-side payload and busy length, master-side completion.
  initial begin
    int   vcnt;
    exp_t e;
    vcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        vcnt = 0;
      end else begin
        chk("slave_exclusive", 160'(bram_valid & uart_valid), 160'(0));
        chk("ready_exclusive", 160'(im_ready & dm_ready), 160'(0));
        if ((bram_valid || uart_valid) && vcnt == 0) begin
          if (exp_q.size() == 0) begin
            chk("valid_no_request", 160'({bram_valid, uart_valid}), 160'(0));
          end else begin
            e = exp_q[0];
            chk("s_region", 160'({bram_valid, uart_valid}),
                160'(e.region == 0 ? 2'b10 : (e.region == 1 ? 2'b01 : 2'b00)));
            chk("s_addr", 160'(s_addr), 160'(e.off));
            chk("s_we", 160'(s_we), 160'(e.we));
            chk("s_wmask", 160'(s_wmask), 160'(e.mask));
            chk("s_wdata", 160'(s_wdata), 160'(e.wdata));
          end
        end
        if (bram_valid || uart_valid) begin
          vcnt++;
        end else if (vcnt > 0) begin
          if (exp_q.size() > 0)
            chk("busy_cycles", 160'(vcnt), 160'(exp_q[0].busy));
          vcnt = 0;
        end
        if (im_ready || dm_ready) begin
          if (exp_q.size() == 0) begin
            chk("ready_no_request", 160'({im_ready, dm_ready}), 160'(0));
          end else begin
            e = exp_q.pop_front();
            chk("ready_master", 160'({im_ready, dm_ready}),
                160'(e.dm ? 2'b01 : 2'b10));
            chk("rdata", 160'(e.dm ? dm_rdata : im_rdata), 160'(e.rdata));
            chk("err", 160'(e.dm ? dm_err : im_err), 160'(e.err));
          end
        end
      end
    end
  end

  // Issue one or two requests, predict order/latency, wait for readies.
  task automatic serve(bit iv, logic [31:0] ia, bit dv, logic [31:0] da,
                       bit dwe, logic [31:0] dwd, logic [3:0] dmk,
                       bit drive);
    exp_t ei;
    exp_t ed;
    int   ci;
    int   cd;
    int   n;
    bit   im_first;
    bit   wi;
    bit   wd;
    ei = predict(1'b0, ia, 1'b0, 32'h0, 4'h0);
    ed = predict(1'b1, da, dwe, dwd, dmk);
    ci = 0;
    cd = 0;
    im_first = !dv || (iv && ref_last);
    if (iv && dv) begin
      ref_last = !im_first;
      if (im_first) begin
        ci = own(ei);
        cd = ci + 1 + own(ed);
        exp_q.push_back(ei);
        exp_q.push_back(ed);
      end else begin
        cd = own(ed);
        ci = cd + 1 + own(ei);
        exp_q.push_back(ed);
        exp_q.push_back(ei);
      end
    end else if (iv) begin
      ci = own(ei);
      exp_q.push_back(ei);
    end else begin
      cd = own(ed);
      exp_q.push_back(ed);
    end
    if (drive) begin
      @(negedge clk);
      im_valid = iv;
      im_addr  = ia;
      dm_valid = dv;
      dm_addr  = da;
      dm_we    = dwe;
      dm_wdata = dwd;
      dm_wmask = dmk;
    end
    wi = iv;
    wd = dv;
    n  = 0;
    while ((wi || wd) && n < 200) begin
      @(negedge clk);
      n++;
      if (wi && im_ready) begin
        chk("im_latency", 160'(n), 160'(ci));
        im_valid = 1'b0;
        wi = 1'b0;
      end
      if (wd && dm_ready) begin
        chk("dm_latency", 160'(n), 160'(cd));
        dm_valid = 1'b0;
        wd = 1'b0;
      end
    end
    if (wi || wd) begin
      chk("ready_wait", 160'({wi, wd}), 160'(0));
      im_valid = 1'b0;
      dm_valid = 1'b0;
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [31:0] bnd [5];
    r = $urandom;
    bnd[0] = 32'h0000_fffc;
    bnd[1] = 32'h0001_0000;
    bnd[2] = 32'h1000_0024;
    bnd[3] = 32'h1000_0028;
    bnd[4] = 32'h0fff_fffc;
    case ($urandom_range(0, 5))
      0, 1:    return {16'h0, r[15:2], 2'b00};
      2:       return 32'h1000_0000 + 32'(4 * $urandom_range(0, 9));
      3:       return r;
      4:       return bnd[$urandom_range(0, 4)];
      default: return {16'h0, r[15:0]};
    endcase
  endfunction

  logic [138:0] all_outs;
  assign all_outs = {im_rdata, im_ready, im_err, dm_rdata, dm_ready, dm_err,
                     s_addr, s_wdata, s_wmask, s_we, bram_valid, uart_valid};

  logic [31:0] bnd_a [5];

  initial begin
    reset_n  = 1'b0;
    im_addr  = 32'h0;
    im_valid = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_wmask = 4'h0;
    dm_we    = 1'b0;
    dm_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 160'(all_outs), 160'(0));
    reset_n = 1'b1;

    slat      = 2;
    bram_data = $urandom;
    uart_data = $urandom;
    serve(1'b1, 32'h0, 1'b1, 32'h1000_0004, 1'b1, 32'h41, 4'b0001, 1'b1);
    serve(1'b1, 32'h8, 1'b1, 32'h1000_0008, 1'b0, 32'h0, 4'hf, 1'b1);

    bram_data = 32'hdead_beef;
    serve(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 4'hf, 1'b1);
    serve(1'b0, 32'h0, 1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'hf, 1'b1);

    bnd_a[0] = 32'h0000_fffc;
    bnd_a[1] = 32'h0001_0000;
    bnd_a[2] = 32'h1000_0024;
    bnd_a[3] = 32'h1000_0028;
    bnd_a[4] = 32'h0fff_fffc;
    for (int i = 0; i < 5; i++) begin
      bram_data = $urandom;
      uart_data = $urandom;
      serve(1'b0, 32'h0, 1'b1, bnd_a[i], 1'b0, 32'h0, 4'hf, 1'b1);
      serve(1'b1, bnd_a[i], 1'b0, 32'h0, 1'b0, 32'h0, 4'hf, 1'b1);
    end

    slat = 0;
    serve(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 4'hf, 1'b1);
    slat = 1;
    serve(1'b0, 32'h0, 1'b1, 32'h1000_0010, 1'b1, $urandom, 4'hf, 1'b1);

    for (int i = 0; i < 150; i++) begin
      int mode;
      spur      = 1'($urandom_range(0, 1));
      slat      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      bram_data = $urandom;
      uart_data = $urandom;
      mode      = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      serve(mode != 1, rand_addr(), mode != 0, rand_addr(),
            1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'b1);
    end

    // Abort a transaction in BUSY with reset, then serve a contended pair.
    spur = 1'b0;
    slat = 0;
    exp_q.push_back(predict(1'b1, 32'h200, 1'b0, 32'h0, 4'hf));
    @(negedge clk);
    dm_valid = 1'b1;
    dm_addr  = 32'h200;
    dm_we    = 1'b0;
    dm_wdata = 32'h0;
    dm_wmask = 4'hf;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 160'(bram_valid), 160'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_abort_outputs", 160'(all_outs), 160'(0));
    exp_q.delete();
    im_valid = 1'b1;
    im_addr  = 32'h300;
    repeat (2) @(negedge clk);
    chk("reset_held_outputs", 160'(all_outs), 160'(0));
    slat      = 2;
    bram_data = $urandom;
    ref_last  = 1'b0;
    reset_n   = 1'b1;
    serve(1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h0, 4'hf, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 160'(exp_q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
